// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared types, constants and the round-robin lane picker for
//               the 1x4 credit-based demux dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

  localparam int LANES  = 4;
  localparam int STAT_W = 16;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    RR   = 1'b0,
    ADDR = 1'b1
  } mode_e;

  // First lane with credit, searching ptr, ptr+1, ... (mod 4).
  // The loop runs backwards so the earliest lane in search order wins.
  // If no lane is eligible the result is unused (ready is low).
  function automatic sel_t rr_pick(input logic [LANES-1:0] avail, input sel_t ptr);
    sel_t pick;
    sel_t cand;
    pick = ptr;
    for (int i = LANES - 1; i >= 0; i--) begin
      cand = sel_t'(ptr + sel_t'(i));
      if (avail[cand]) pick = cand;
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_credit_ctr.sv
`default_nettype none
// ============================================================================
// Module      : lane_credit_ctr
// Description : Per-lane credit counter. Starts full at CREDITS, counts down
//               on a send, up on a credit return, saturates at CREDITS and
//               flags a return that arrives while already full.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_credit_ctr #(
  parameter  int CREDITS = 4,
  localparam int CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          avail,
  output logic          ovf
);

  localparam logic [CW-1:0] C_FULL = CW'(CREDITS);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  // Up/down counter; a simultaneous send and return cancel each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= C_FULL;
    end else if (dec && !inc) begin
      count <= count - C_ONE;
    end else if (inc && !dec && (count != C_FULL)) begin
      count <= count + C_ONE;
    end
  end

  assign avail = (count != '0);
  // A return into a full counter is dropped and reported.
  assign ovf   = inc && !dec && (count == C_FULL);

endmodule
`default_nettype wire

// File: rtl/demux_dispatch_1x4.sv
`default_nettype none
// ============================================================================
// Module      : demux_dispatch_1x4
// Description : Credit-based dispatcher in front of a 1-to-4 demux. Accepts
//               words over valid/ready, picks a lane (round-robin or
//               addressed), and only sends to lanes holding credit.
//               Optional macro DEMUX_DISPATCH_STATS_EN adds per-lane transfer
//               counters and a stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_dispatch_1x4
  import demux_pkg::*;
#(
  parameter int N       = 3,
  parameter int CREDITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [N:0]            data_i,
  input  logic [1:0]            dest_i,
  input  logic                  mode_i,
  input  logic [LANES-1:0]      credit_ret_i,
  output logic [N:0]            data_o,
  output logic [1:0]            sel_o,
  output logic [LANES-1:0]      lane_valid_o,
  output logic                  err_o
`ifdef DEMUX_DISPATCH_STATS_EN
  ,
  output logic [3:0][STAT_W-1:0] stat_cnt_o,
  output logic [STAT_W-1:0]      stall_cnt_o
`endif
);

  localparam int CW = $clog2(CREDITS + 1);

  logic [CW-1:0]    credit [LANES];
  logic [LANES-1:0] avail;
  logic [LANES-1:0] ovf;
  logic [LANES-1:0] lane_dec;
  sel_t             rr_ptr;
  sel_t             target;
  logic             addressed;
  logic             transfer;

  assign addressed = (mode_e'(mode_i) == ADDR);

  // Lane choice and acceptance, from registered credits only (no bypass).
  always_comb begin
    target  = rr_pick(avail, rr_ptr);
    ready_o = |avail;
    if (addressed) begin
      target  = dest_i;
      ready_o = (credit[dest_i] != '0);
    end
  end

  assign transfer = valid_i && ready_o;
  assign lane_dec = transfer ? (LANES'(1) << target) : '0;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_credit_ctr #(
      .CREDITS (CREDITS)
    ) u_ctr (
      .clk   (clk_i),
      .rst   (rst_i),
      .dec   (lane_dec[k]),
      .inc   (credit_ret_i[k]),
      .count (credit[k]),
      .avail (avail[k]),
      .ovf   (ovf[k])
    );
  end

  // Output register toward the demux; idle cycles drive zero data/strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o       <= '0;
      sel_o        <= '0;
      lane_valid_o <= '0;
      rr_ptr       <= '0;
    end else if (transfer) begin
      data_o       <= data_i;
      sel_o        <= target;
      lane_valid_o <= lane_dec;
      rr_ptr       <= target + sel_t'(1);
    end else begin
      data_o       <= '0;
      lane_valid_o <= '0;
    end
  end

  // Sticky credit-overflow flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (|ovf) begin
      err_o <= 1'b1;
    end
  end

`ifdef DEMUX_DISPATCH_STATS_EN
  // Per-lane transfer counts (wrapping) and stall cycles (saturating).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_dec[k]) stat_cnt_o[k] <= stat_cnt_o[k] + STAT_W'(1);
      end
      if (valid_i && !ready_o && (stall_cnt_o != {STAT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + STAT_W'(1);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_dispatch_1x4.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_dispatch_1x4
// Description : Self-checking bench for demux_dispatch_1x4 with a lane/credit
//               model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_dispatch_1x4;

  localparam int N       = 3;
  localparam int CREDITS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       ready;
  logic [N:0] data_in;
  logic [1:0] dest;
  logic       mode;
  logic [3:0] ret;
  logic [N:0] data_out;
  logic [1:0] sel;
  logic [3:0] lane_valid;
  logic       err;

  int checks = 0;
  int errors = 0;

  demux_dispatch_1x4 #(.N(N), .CREDITS(CREDITS)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .valid_i      (valid),
    .ready_o      (ready),
    .data_i       (data_in),
    .dest_i       (dest),
    .mode_i       (mode),
    .credit_ret_i (ret),
    .data_o       (data_out),
    .sel_o        (sel),
    .lane_valid_o (lane_valid),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_cred[4];
  int m_rr;
  bit m_err;
  int m_data, m_sel, m_lv;

  function automatic int m_target();
    if (mode) return int'(dest);
    for (int i = 0; i < 4; i++) begin
      if (m_cred[(m_rr + i) % 4] > 0) return (m_rr + i) % 4;
    end
    return 0;
  endfunction

  function automatic bit m_ready();
    if (mode) return m_cred[dest] > 0;
    for (int i = 0; i < 4; i++) if (m_cred[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) m_cred[k] = CREDITS;
      m_rr = 0; m_err = 0; m_data = 0; m_sel = 0; m_lv = 0;
    end else begin
      bit xfer;
      int tgt;
      xfer = valid && m_ready();
      tgt  = m_target();
      for (int k = 0; k < 4; k++) begin
        bit d;
        d = xfer && (tgt == k);
        if (d && !ret[k]) m_cred[k]--;
        else if (ret[k] && !d) begin
          if (m_cred[k] == CREDITS) m_err = 1;
          else m_cred[k]++;
        end
      end
      if (xfer) begin
        m_data = int'(data_in);
        m_sel  = tgt;
        m_lv   = 1 << tgt;
        m_rr   = (tgt + 1) % 4;
      end else begin
        m_data = 0;
        m_lv   = 0;
      end
    end
  end

  // Every-cycle comparison, mid-cycle away from the sampling edge.
  always @(negedge clk) begin
    check("ready", 32'(ready), 32'(m_ready()));
    check("data_o", 32'(data_out), 32'(m_data));
    check("sel_o", 32'(sel), 32'(m_sel));
    check("lane_valid", 32'(lane_valid), 32'(m_lv));
    check("err_o", 32'(err), 32'(m_err));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; ret = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  int exp_sel[6] = '{0, 1, 2, 3, 0, 1};
  int exp_lv[6]  = '{1, 2, 4, 8, 1, 2};

  initial begin
    rst = 1'b1; valid = 0; data_in = 0; dest = 0; mode = 0; ret = 0;
    do_reset();
    #1;
    check("rst data_o", 32'(data_out), 0);
    check("rst sel_o", 32'(sel), 0);
    check("rst lane_valid", 32'(lane_valid), 0);
    check("rst err_o", 32'(err), 0);
    check("rst ready", 32'(ready), 1);

    // Round-robin sweep.
    mode = 0;
    for (int i = 0; i < 6; i++) begin
      valid = 1; data_in = 4'(i + 1);
      tick();
      check("rr sel", 32'(sel), 32'(exp_sel[i]));
      check("rr lane_valid", 32'(lane_valid), 32'(exp_lv[i]));
      check("rr data", 32'(data_out), 32'(i + 1));
    end
    valid = 0;

    // Addressed burst until lane 2 runs dry, then one credit back.
    do_reset();
    mode = 1; dest = 2;
    for (int i = 0; i < 6; i++) begin
      valid = 1; data_in = 4'(i);
      #1 check("addr ready", 32'(ready), 32'(i < 4));
      tick();
    end
    check("addr dry ready", 32'(ready), 0);
    ret = 4'b0100;
    tick();
    ret = 4'b0000;
    #1 check("addr credit back", 32'(ready), 1);
    data_in = 4'h9;
    tick();
    check("addr extra lane", 32'(lane_valid), 32'h4);
    check("addr extra data", 32'(data_out), 32'h9);
    #1 check("addr dry again", 32'(ready), 0);
    valid = 0;

    // RR skip over an empty lane.
    do_reset();
    mode = 1; dest = 1; valid = 1;
    repeat (4) tick();
    dest = 0;
    tick();
    mode = 0; data_in = 4'h5;
    tick();
    check("skip sel", 32'(sel), 2);
    check("skip lane_valid", 32'(lane_valid), 32'h4);
    data_in = 4'h6;
    tick();
    check("skip next sel", 32'(sel), 3);
    valid = 0;

    // Same-cycle send and return on lane 0.
    do_reset();
    mode = 1; dest = 0; valid = 1;
    repeat (3) tick();
    ret = 4'b0001;
    tick();
    ret = 4'b0000;
    #1;
    check("cancel ready", 32'(ready), 1);
    check("cancel err", 32'(err), 0);
    check("cancel lane", 32'(lane_valid), 1);
    tick();
    #1 check("cancel drained", 32'(ready), 0);
    valid = 0;

    // Overflow return sets a sticky error.
    do_reset();
    ret = 4'b0001;
    tick();
    ret = 4'b0000;
    check("ovf err", 32'(err), 1);
    repeat (3) tick();
    check("ovf err sticky", 32'(err), 1);
    mode = 1; dest = 0; valid = 1;
    repeat (4) tick();
    #1 check("ovf no extra credit", 32'(ready), 0);
    valid = 0;
    do_reset();
    check("ovf err cleared", 32'(err), 0);

    // Asynchronous reset mid-stream.
    mode = 1; dest = 2; valid = 1; data_in = 4'hC;
    tick();
    valid = 0;
    check("pre-rst lane", 32'(lane_valid), 32'h4);
    #1 rst = 1'b1;
    #1;
    check("async lane_valid", 32'(lane_valid), 0);
    check("async data_o", 32'(data_out), 0);
    check("async sel_o", 32'(sel), 0);
    @(posedge clk); #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mode = 1; dest = 2'(k); valid = 1; data_in = 4'(k);
      repeat (4) tick();
      #1 check("reload credits", 32'(ready), 0);
      valid = 0;
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_dispatch_1x4.md
# demux_dispatch_1x4

Credit-based dispatcher that sits directly upstream of the 1-to-4 demux. It accepts a stream of words over a valid/ready handshake, picks a destination lane (round-robin or addressed), and tracks per-lane credits so a word is never sent to a lane that cannot absorb it. Its registered outputs drive the demux `data_i`/`sel_i` directly, plus a one-hot lane strobe.

## Interface
- `N`, 3: data width minus 1; data is `N+1` bits.
- `CREDITS`, 4: initial and maximum credits per lane, range 1..15.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `valid_i` in 1: input word valid.
- `ready_o` out 1: input word accepted this cycle when high together with `valid_i`.
- `data_i` in N+1: input word.
- `dest_i` in 2: destination lane, used in addressed mode only.
- `mode_i` in 1: 0 = round-robin, 1 = addressed.
- `credit_ret_i` in 4: per-lane credit return; one pulse returns one credit.
- `data_o` out N+1: word to the demux `data_i`.
- `sel_o` out 2: lane to the demux `sel_i`.
- `lane_valid_o` out 4: one-hot strobe for the lane receiving `data_o`.
- `err_o` out 1: sticky flag for credit-return overflow.

## Operation
- Credits: one counter per lane, width `$clog2(CREDITS+1)`. A lane is eligible when its count is above 0.
- Target in addressed mode: `dest_i`.
  - `ready_o` = credit[`dest_i`] > 0.
- Target in round-robin mode: the first eligible lane searching `rr_ptr`, `rr_ptr+1`, … mod 4.
  - `ready_o` = any lane eligible.
- `ready_o` is combinational from the registered credits, `mode_i` and `dest_i`. It does not depend on `valid_i`.
- Transfer (`valid_i & ready_o`):
  - Register `data_i` into `data_o` and the target into `sel_o`.
  - Set `lane_valid_o` to one-hot(target).
  - Decrement credit[target].
  - Set `rr_ptr` to (target+1) mod 4. This happens in both modes.
- No transfer: `lane_valid_o` = 0 and `data_o` = 0, so demux outputs stay zero. `sel_o` holds its last value.
- Credit return: `credit_ret_i[k]` increments credit[k].
  - If a transfer to lane k happens in the same cycle, the count is unchanged.
  - A return while credit[k] == CREDITS (with no same-cycle decrement) saturates the count and sets `err_o`.
  - `err_o` clears only on reset.
- `mode_i`/`dest_i` are sampled only in transfer cycles. Changing them mid-stream needs no special handling.
- `rr_ptr` is 2 bits and wraps 3 -> 0.

## Timing
- Reset values:
  - `data_o` = 0, `sel_o` = 0, `lane_valid_o` = 0, `err_o` = 0.
  - All credits = CREDITS, `rr_ptr` = 0.
  - `ready_o` evaluates to 1 after reset.
- Latency: a word accepted at edge t appears on `data_o`/`sel_o`/`lane_valid_o` from edge t until edge t+1, i.e. one cycle.
- Throughput: one word per cycle while the target has credit. Back-to-back sends to one lane are allowed until its credit reaches 0.
- Credit returned at edge t makes the lane eligible for `ready_o` in the cycle after edge t. There is no combinational credit bypass.
- Reset mid-stream: outputs clear immediately. Any in-flight word and outstanding credits are discarded, and credits reload to CREDITS.

## Configuration
- Macro: `DEMUX_DISPATCH_STATS_EN`.
- Defined:
  - Adds output `stat_cnt_o[3:0][15:0]`, a per-lane count of transfers that wraps 0xFFFF -> 0.
  - Adds output `stall_cnt_o[15:0]`, which counts cycles with `valid_i & !ready_o` and saturates at 0xFFFF.
  - All counters reset to 0.
- Undefined: the ports and logic are absent, and the core behaviour is unchanged.

## Structure
- Package `demux_pkg`:
  - `LANES` = 4.
  - `sel_t` (logic [1:0]).
  - `mode_e` (RR = 0, ADDR = 1).
  - Stats counter width constant.
- Sub-module `lane_credit_ctr`, instantiated 4 times.
  - Parameter: CREDITS.
  - Inputs: dec, inc.
  - Outputs: count, avail, ovf.
  - Contains the saturating up/down counter.
- Top level holds the target select, round-robin pointer, output register and stats.

## Test plan
- Reset, `mode_i` = 0, `valid_i` held high with data 0x1,0x2,…,0x6, no credit returns -> `sel_o` sequence 0,1,2,3,0,1. `lane_valid_o` sequence 0001,0010,0100,1000,0001,0010, each one cycle after acceptance.
- `mode_i` = 1, `dest_i` = 2, CREDITS = 4, 6 words, no returns -> 4 words accepted on consecutive cycles, then `ready_o` = 0. One `credit_ret_i` = 0100 -> `ready_o` = 1 next cycle and exactly one more word is accepted.
- RR mode with credit[1] exhausted, `rr_ptr` = 1 -> word goes to lane 2 (`sel_o` = 2), and `rr_ptr` becomes 3.
- Lane 0 at credit 1: transfer to lane 0 plus `credit_ret_i[0]` in the same cycle -> credit[0] stays 1 and `ready_o` stays high for `dest_i` = 0.
- After reset, `credit_ret_i` = 0001 -> `err_o` = 1 next cycle and stays 1. credit[0] stays 4. After `rst_i` pulse, `err_o` = 0.
- Assert `rst_i` asynchronously while `lane_valid_o` = 0100 -> `lane_valid_o`, `data_o`, `sel_o` go to 0 without a clock edge, and all credits read 4 after release.
